// File: rtl/rv32i_defs.sv
// Shared definitions for the RV32I memory subsystem: widths, request bundle
// and arbitration policy encoding.
package rv32i_defs;

  localparam int ADDR_WIDTH = 10;
  localparam int WORD_WIDTH = 32;

  typedef struct packed {
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] wdata;
  } mem_req_t;

  typedef enum logic {
    ARB_RR        = 1'b0,
    ARB_DATA_PRIO = 1'b1
  } arb_mode_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant between the data port and the fetch port, either round-robin
// on conflict or with fixed data-port priority.
module rr_arb2
  import rv32i_defs::*;
#(
  parameter arb_mode_e MODE = ARB_RR
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_dm,
  input  logic req_if,
  output logic gnt_dm,
  output logic gnt_if
);

  // 0 favours the data port on the next conflict, 1 favours fetch.
  logic ptr;

  always_comb begin
    gnt_dm = 1'b0;
    gnt_if = 1'b0;
    if (req_dm && req_if) begin
      if ((MODE == ARB_DATA_PRIO) || !ptr) gnt_dm = 1'b1;
      else                                 gnt_if = 1'b1;
    end else begin
      gnt_dm = req_dm;
      gnt_if = req_if;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                ptr <= 1'b0;
    else if (req_dm && req_if) ptr <= gnt_dm;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and the
// data port; read data returns one cycle after grant with an owner tag.
module mem_arbiter
  import rv32i_defs::*;
#(
  parameter int ADDR_WIDTH = rv32i_defs::ADDR_WIDTH,
  parameter int WORD_WIDTH = rv32i_defs::WORD_WIDTH,
  parameter int ARB_MODE   = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [WORD_WIDTH-1:0] if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [WORD_WIDTH-1:0] dm_wdata,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [WORD_WIDTH-1:0] dm_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  localparam arb_mode_e MODE = (ARB_MODE == 1) ? ARB_DATA_PRIO : ARB_RR;

  logic own_if;
  logic own_dm;
  logic stall;

  rr_arb2 #(.MODE(MODE)) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_dm (dm_req),
    .req_if (if_req),
    .gnt_dm (dm_gnt),
    .gnt_if (if_gnt)
  );

  // Handshake: a request is taken on the edge where req and gnt are both high;
  // the requester holds req/addr/we/wdata stable until then.
  always_comb begin
    mem_read  = if_gnt | (dm_gnt & ~dm_we);
    mem_write = dm_gnt & dm_we;
    mem_addr  = if_gnt ? if_addr : dm_addr;
    mem_wdata = dm_wdata;
  end

  assign stall = (if_req & ~if_gnt) | (dm_req & ~dm_gnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_if    <= 1'b0;
      own_dm    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      own_if <= if_gnt;
      own_dm <= dm_gnt & ~dm_we;
      if (stall && !(&stall_cnt))
        stall_cnt <= stall_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign if_rvalid = own_if;
  assign dm_rvalid = own_dm;
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: round-robin DUT with a memory model, a data-priority DUT and
// a narrow-counter DUT, all driven by the same request stimulus.
module tb_mem_arbiter;

  localparam int AW = 10;
  localparam int WW = 32;

  logic          clk;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [WW-1:0] dm_wdata;
  logic [WW-1:0] mem_rdata0;
  logic [WW-1:0] zero_word;
  logic [WW-1:0] mem [0:1023];

  logic          if_gnt0, if_rvalid0, dm_gnt0, dm_rvalid0, mem_read0, mem_write0;
  logic [WW-1:0] if_rdata0, dm_rdata0, mem_wdata0;
  logic [AW-1:0] mem_addr0;
  logic [15:0]   stall_cnt0;

  logic          if_gnt1, if_rvalid1, dm_gnt1, dm_rvalid1, mem_read1, mem_write1;
  logic [WW-1:0] if_rdata1, dm_rdata1, mem_wdata1;
  logic [AW-1:0] mem_addr1;
  logic [15:0]   stall_cnt1;

  logic          if_gnt2, if_rvalid2, dm_gnt2, dm_rvalid2, mem_read2, mem_write2;
  logic [WW-1:0] if_rdata2, dm_rdata2, mem_wdata2;
  logic [AW-1:0] mem_addr2;
  logic [3:0]    stall_cnt2;

  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory with registered read data, attached to the RR DUT.
  always @(posedge clk) begin
    if (mem_write0) mem[mem_addr0] <= mem_wdata0;
    if (mem_read0)  mem_rdata0     <= mem[mem_addr0];
  end

  mem_arbiter #(.ARB_MODE(0), .CNT_WIDTH(16)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt0),
    .if_rvalid(if_rvalid0), .if_rdata(if_rdata0),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt0), .dm_rvalid(dm_rvalid0), .dm_rdata(dm_rdata0),
    .mem_read(mem_read0), .mem_write(mem_write0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0), .stall_cnt(stall_cnt0)
  );

  mem_arbiter #(.ARB_MODE(1), .CNT_WIDTH(16)) dut_prio (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1),
    .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt1), .dm_rvalid(dm_rvalid1), .dm_rdata(dm_rdata1),
    .mem_read(mem_read1), .mem_write(mem_write1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(zero_word), .stall_cnt(stall_cnt1)
  );

  mem_arbiter #(.ARB_MODE(0), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt2),
    .if_rvalid(if_rvalid2), .if_rdata(if_rdata2),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt2), .dm_rvalid(dm_rvalid2), .dm_rdata(dm_rdata2),
    .mem_read(mem_read2), .mem_write(mem_write2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(zero_word), .stall_cnt(stall_cnt2)
  );

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    if_req   = 1'b0;
    if_addr  = '0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
  endtask

  // ---------------- directed sequence ----------------
  logic [3:0] rr_dm_tbl;

  initial begin
    zero_word  = '0;
    mem_rdata0 = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[10'h010] = 32'hDEADBEEF;
    mem[10'h001] = 32'h11111111;
    mem[10'h002] = 32'h22222222;
    rr_dm_tbl    = 4'b0101;   // expected data grants on conflict cycles 0..3
    idle();
    rst_n = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_rvalid", {31'b0, if_rvalid0}, 32'd0);
    chk("rst_dm_rvalid", {31'b0, dm_rvalid0}, 32'd0);
    chk("rst_stall_rr", {16'b0, stall_cnt0}, 32'd0);
    chk("rst_stall_sat", {28'b0, stall_cnt2}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single fetch from 0x10
    if_req = 1'b1; if_addr = 10'h010;
    #1;
    chk("fetch_gnt", {31'b0, if_gnt0}, 32'd1);
    chk("fetch_no_dm_gnt", {31'b0, dm_gnt0}, 32'd0);
    chk("fetch_mem_read", {31'b0, mem_read0}, 32'd1);
    chk("fetch_mem_addr", {22'b0, mem_addr0}, 32'h10);
    tick();
    if_req = 1'b0;
    chk("fetch_rvalid", {31'b0, if_rvalid0}, 32'd1);
    chk("fetch_rdata", if_rdata0, 32'hDEADBEEF);
    chk("fetch_dm_rvalid", {31'b0, dm_rvalid0}, 32'd0);
    tick();
    chk("fetch_rvalid_drop", {31'b0, if_rvalid0}, 32'd0);

    // Store 0x12345678 to 0x20, then load it back
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'h020; dm_wdata = 32'h12345678;
    #1;
    chk("st_gnt", {31'b0, dm_gnt0}, 32'd1);
    chk("st_mem_write", {31'b0, mem_write0}, 32'd1);
    chk("st_mem_read", {31'b0, mem_read0}, 32'd0);
    chk("st_mem_wdata", mem_wdata0, 32'h12345678);
    tick();
    dm_we = 1'b0;
    #1;
    chk("st_no_rvalid", {31'b0, dm_rvalid0}, 32'd0);
    chk("ld_mem_read", {31'b0, mem_read0}, 32'd1);
    chk("ld_mem_write", {31'b0, mem_write0}, 32'd0);
    tick();
    dm_req = 1'b0;
    chk("ld_rvalid", {31'b0, dm_rvalid0}, 32'd1);
    chk("ld_rdata", dm_rdata0, 32'h12345678);
    chk("ld_if_rvalid", {31'b0, if_rvalid0}, 32'd0);
    chk("no_stall_yet", {16'b0, stall_cnt0}, 32'd0);

    // Conflict for 4 cycles: fetch 0x01, load 0x02
    if_req = 1'b1; if_addr = 10'h001;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h002;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("rr_dm_gnt", {31'b0, dm_gnt0}, {31'b0, rr_dm_tbl[c]});
      chk("rr_if_gnt", {31'b0, if_gnt0}, {31'b0, ~rr_dm_tbl[c]});
      chk("rr_rw_excl", {31'b0, mem_read0 & mem_write0}, 32'd0);
      chk("prio_dm_gnt", {31'b0, dm_gnt1}, 32'd1);
      chk("prio_if_gnt", {31'b0, if_gnt1}, 32'd0);
      tick();
      chk("rr_dm_rvalid", {31'b0, dm_rvalid0}, {31'b0, rr_dm_tbl[c]});
      chk("rr_if_rvalid", {31'b0, if_rvalid0}, {31'b0, ~rr_dm_tbl[c]});
      chk("rr_rdata", dm_rdata0, rr_dm_tbl[c] ? 32'h22222222 : 32'h11111111);
    end
    chk("rr_stall4", {16'b0, stall_cnt0}, 32'd4);
    chk("prio_stall4", {16'b0, stall_cnt1}, 32'd4);
    chk("sat_stall4", {28'b0, stall_cnt2}, 32'd4);

    // Data port drops: fetch is granted immediately in priority mode
    dm_req = 1'b0;
    #1;
    chk("prio_if_after_drop", {31'b0, if_gnt1}, 32'd1);
    chk("rr_if_after_drop", {31'b0, if_gnt0}, 32'd1);
    tick();
    idle();
    chk("stall_held", {16'b0, stall_cnt1}, 32'd4);
    tick();

    // Reset asserted after a fetch grant, before the capturing edge
    if_req = 1'b1; if_addr = 10'h010;
    #1;
    chk("rm_gnt", {31'b0, if_gnt0}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rm_no_rvalid", {31'b0, if_rvalid0}, 32'd0);
    chk("rm_stall_rr", {16'b0, stall_cnt0}, 32'd0);
    chk("rm_stall_prio", {16'b0, stall_cnt1}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rm_after_rvalid", {31'b0, if_rvalid0}, 32'd1);
    chk("rm_after_rdata", if_rdata0, 32'hDEADBEEF);
    idle();
    tick();

    // 20 conflict cycles: narrow counter saturates at 0xF
    if_req = 1'b1; if_addr = 10'h001;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h002;
    for (int c = 0; c < 20; c++) begin
      #1;
      chk("sat_gnt_excl", {31'b0, if_gnt0 & dm_gnt0}, 32'd0);
      chk("sat_rw_excl", {31'b0, mem_read0 & mem_write0}, 32'd0);
      tick();
    end
    idle();
    chk("sat_cnt", {28'b0, stall_cnt2}, 32'hF);
    chk("wide_cnt_rr", {16'b0, stall_cnt0}, 32'd20);
    chk("wide_cnt_prio", {16'b0, stall_cnt1}, 32'd20);
    tick();
    chk("sat_hold", {28'b0, stall_cnt2}, 32'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter/sequencer in front of the single-port synchronous memory of the RV32I core.
- Shares the memory between the instruction-fetch port (read-only) and the data port (load/store).
- Guarantees read and write strobes are never asserted together.
- Returns read data with a registered valid tag to the owning requester, and counts conflict stalls.

Parameters:
- ADDR_WIDTH, `ADDR_WIDTH, word-address width shared with the memory.
- WORD_WIDTH, `WORD_WIDTH, data word width.
- ARB_MODE, 0, arbitration policy: 0 = round-robin on conflict, 1 = data port has fixed priority.
- CNT_WIDTH, 16, width of the stall counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch read request
- if_addr  in  ADDR_WIDTH  fetch word address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  WORD_WIDTH  fetch data
- dm_req  in  1  data request
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_WIDTH  data word address
- dm_wdata  in  WORD_WIDTH  store data
- dm_gnt  out  1  data request accepted this cycle
- dm_rvalid  out  1  load data valid
- dm_rdata  out  WORD_WIDTH  load data
- mem_read  out  1  to memory read strobe
- mem_write  out  1  to memory write strobe
- mem_addr  out  ADDR_WIDTH  to memory address
- mem_wdata  out  WORD_WIDTH  to memory write data
- mem_rdata  in  WORD_WIDTH  from memory data out (registered inside the memory)
- stall_cnt  out  CNT_WIDTH  conflict-stall counter

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. While rst_n = 0, all registered state clears: rr_ptr = 0 (points to data port), rvalid pipeline = 0, stall_cnt = 0.
- Grant (combinational):
  - At most one gnt is high per cycle.
  - Only if_req high: if_gnt = 1.
  - Only dm_req high: dm_gnt = 1.
  - Both high, ARB_MODE = 1: dm_gnt = 1.
  - Both high, ARB_MODE = 0: grant goes to rr_ptr (0 = data, 1 = fetch).
  - A request is accepted when req & gnt at the clock edge. Requesters hold req, addr, we and wdata stable until granted.
- Memory drive (combinational from the winning request):
  - Fetch granted: mem_read = 1.
  - Data read granted: mem_read = 1.
  - Data write granted: mem_write = 1.
  - No grant: mem_read = mem_write = 0.
  - mem_addr and mem_wdata mux from the winner; mem_wdata = dm_wdata for writes, don't-care otherwise.
  - mem_read & mem_write is never 1.
- Round-robin pointer: updates only on a conflict cycle (both requests high). Becomes 1 after a data grant and 0 after a fetch grant. It is unchanged when only one port requests.
- Read latency is exactly 1 cycle after grant:
  - Registered owner tags are set on any accepted read: own_if <= if_gnt; own_dm <= dm_gnt & ~dm_we.
  - if_rvalid = own_if; dm_rvalid = own_dm.
  - if_rdata = dm_rdata = mem_rdata (pass-through). They are meaningful only while the matching rvalid is high.
  - Back-to-back grants give one response per cycle. Full throughput: no bubbles.
- Writes complete at grant. A write never raises dm_rvalid.
- stall_cnt increments by 1 in every cycle where a request is high and its gnt is low. It saturates at all-ones and does not wrap.
- Reset mid-operation: a read granted in the cycle reset asserts produces no rvalid after reset. Memory contents are untouched.
- Simultaneous reset release and requests: arbitration is live from the first clk edge after rst_n rises.

Decomposition:
- Shared package rv32i_defs: ADDR_WIDTH, WORD_WIDTH, the typedef mem_req_t {req, we, addr, wdata}, and the enum arb_mode_e {ARB_RR, ARB_DATA_PRIO}.
- One natural sub-module: rr_arb2, a 2-way round-robin/fixed-priority grant with pointer register.

Test Plan:
- Single fetch: if_req = 1, if_addr = 0x10 (memory preloaded 0x10 = 0xDEADBEEF) -> if_gnt = 1 same cycle; if_rvalid = 1 and if_rdata = 0xDEADBEEF next cycle; dm_rvalid stays 0.
- Store then load: dm write addr 0x20, data 0x12345678; next cycle dm read addr 0x20 -> mem_write then mem_read on consecutive cycles; dm_rvalid = 1 with 0x12345678 on cycle 3; no write rvalid.
- Conflict, ARB_MODE = 0: both request for 4 cycles, reading 0x01/0x02 -> grants alternate dm, if, dm, if; stall_cnt = 4; never both gnt; mem_read & mem_write never both 1.
- Conflict, ARB_MODE = 1: both request for 3 cycles -> dm_gnt every cycle, if_gnt = 0; stall_cnt = 3; fetch granted on the first cycle dm_req drops.
- Reset mid-read: grant a fetch at 0x10, assert rst_n = 0 before the next edge -> if_rvalid = 0, stall_cnt = 0; after release, a fetch at 0x10 returns 0xDEADBEEF normally.
- Saturation: CNT_WIDTH = 4 override, 20 conflict cycles -> stall_cnt holds at 0xF.
